clock_divider_multi: RTL and testbench
======================================

# clock_divider_multi

Multi-channel, runtime-programmable clock divider for the capture pipeline. Each of `CHANNELS` channels divides `input_clock` by its own `DIV_WIDTH`-bit ratio and produces a registered square wave (`output_clock`) and a one-cycle period strobe (`output_tick`). Ratio changes are staged and take effect only at a period boundary, so output waveforms never contain runt pulses. An optional sync input phase-aligns all channels.

## Interface
- `CHANNELS`, 4: number of independent divider channels (1..16).
- `DIV_WIDTH`, 8: width of each division ratio.
- `DEFAULT_DIVISION`, 2: ratio loaded into every channel at reset (1..2^DIV_WIDTH-1).

- `input_clock`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  CHANNELS  per-channel run enable.
- `sync`  in  1  phase-align pulse (active only with `CLOCK_DIVIDER_SYNC_EN`).
- `cfg_valid`  in  1  ratio write request.
- `cfg_channel`  in  4  target channel index.
- `cfg_divisor`  in  DIV_WIDTH  new ratio; 0 = channel stopped.
- `cfg_ready`  out  1  write accepted on this edge when high with `cfg_valid`.
- `cfg_pending`  out  CHANNELS  staged ratio waiting for period boundary.
- `output_clock`  out  CHANNELS  divided clock, registered.
- `output_tick`  out  CHANNELS  one-cycle strobe at start of each period.

## Operation
- Per channel: active ratio N, shadow ratio S, pending bit P, counter `cnt` (0..N-1), high length H = ceil(N/2).
- Each edge, channel running (reset low, `enable` high, N≠0): `output_tick` <= (cnt==0); `output_clock` <= (cnt<H); cnt <= (cnt==N-1) ? 0 : cnt+1.
- Resulting waveforms: N=1 -> `output_clock` constant 1, tick every cycle; N=2 -> 1,0; N=3 -> 1,1,0; N=4 -> 1,1,0,0.
- Channel idle (`enable` low or N==0): cnt held 0, both outputs 0.
- Config: `cfg_ready` = !P[`cfg_channel`]; if `cfg_channel` >= CHANNELS, `cfg_ready`=1 and the write is dropped. Accept (`cfg_valid`&&`cfg_ready`): S <= `cfg_divisor`, P <= 1.
- Apply: on an edge where P==1 and (cnt==N-1 while running, or channel idle, or sync applies): N <= S, P <= 0, cnt <= 0. A write accepted on the same edge as a wrap is applied at the next boundary, never the same edge.
- Applying while running: outputs on that edge computed from old N (completes old period); next period uses new N.
- Sync (macro on): on an edge with `sync`=1, every running channel behaves as if cnt==0: tick<=1, clock<=1, cnt<=(N==1)?0:1; pending ratios applied first, so the aligned period uses S.

## Timing
- Reset: cnt=0, N=`DEFAULT_DIVISION`, S=0, P=0, `output_clock`=0, `output_tick`=0, `cfg_pending`=0; `cfg_ready`=1.
- Latency: first rising edge with reset low and enable high -> tick=1, clock=1 on that edge's outputs (1 cycle).
- Enable deassert: outputs 0 on next edge; re-assert restarts at cnt==0 (tick on first enabled edge).
- Reset mid-period: all state returns to reset values on that edge; staged writes lost.
- `cfg_pending` reflects P directly (registered).

## Configuration
- `CLOCK_DIVIDER_SYNC_EN` defined: `sync` functional as above.
- Undefined: `sync` port present but ignored; no alignment logic synthesised; channels align only through common reset/enable.

## Test plan
- Reset then enable all, default ratio 2 -> each `output_clock` 1,0,1,0…; tick on cycles 1,3,5.
- Write ch1=3, ch2=1, ch3=4 while idle -> applied next edge; outputs 1,1,0 / constant 1 / 1,1,0,0; ticks every 3/1/4 cycles.
- Ch0 running N=4, write 5 at cnt=1 -> `cfg_pending`[0]=1, second write same channel sees `cfg_ready`=0; current period finishes 4 cycles, next periods 5 cycles (1,1,1,0,0).
- Write `cfg_divisor`=0 to ch2 -> after boundary outputs 0, `cfg_pending` clears; `cfg_channel`=9 -> `cfg_ready`=1, no state change.
- With macro: ch0 N=3, ch1 N=4 at arbitrary phases, pulse `sync` -> both tick on same edge, thereafter ch0 ticks every 3, ch1 every 4 from that edge; without macro, pulse has no effect.
- Assert reset mid-period with pending write -> all outputs 0, N=2, pending lost; resumes 1,0 pattern after release.

Source files
------------

// File: rtl/clock_divider_multi.sv
// Multi-channel runtime-programmable clock divider with staged, boundary-applied ratio changes.
// Optional phase alignment through the sync input is compiled in with CLOCK_DIVIDER_SYNC_EN.
module clock_divider_multi #(
    parameter int CHANNELS         = 4,
    parameter int DIV_WIDTH        = 8,
    parameter int DEFAULT_DIVISION = 2
) (
    input  logic                 input_clock,
    input  logic                 reset,
    input  logic [CHANNELS-1:0]  enable,
    input  logic                 sync,
    input  logic                 cfg_valid,
    input  logic [3:0]           cfg_channel,
    input  logic [DIV_WIDTH-1:0] cfg_divisor,
    output logic                 cfg_ready,
    output logic [CHANNELS-1:0]  cfg_pending,
    output logic [CHANNELS-1:0]  output_clock,
    output logic [CHANNELS-1:0]  output_tick
);

    localparam logic [DIV_WIDTH-1:0] DEFAULT_N = DIV_WIDTH'(DEFAULT_DIVISION);
    localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH:0]   ONE_WIDE  = (DIV_WIDTH + 1)'(1);

`ifndef CLOCK_DIVIDER_SYNC_EN
    logic unused_sync;
    assign unused_sync = sync;
`endif

    // Out-of-range channel indices never match, so such writes are accepted and dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_channel == 4'(i)) begin
                cfg_ready = ~cfg_pending[i];
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_channel
        logic [DIV_WIDTH-1:0] ratio;
        logic [DIV_WIDTH-1:0] shadow;
        logic [DIV_WIDTH-1:0] cnt;
        logic [DIV_WIDTH-1:0] ratio_eff;
        logic [DIV_WIDTH:0]   high_len;
        logic                 pending;
        logic                 clock_q;
        logic                 tick_q;
        logic                 sync_hit;
        logic                 accept;
        logic                 running;
        logic                 at_wrap;

`ifdef CLOCK_DIVIDER_SYNC_EN
        assign sync_hit = sync;
`else
        assign sync_hit = 1'b0;
`endif

        // A sync pulse folds any staged ratio in first so the aligned period already uses it.
        assign ratio_eff = (sync_hit && pending) ? shadow : ratio;
        assign running   = enable[c] && (ratio_eff != '0);
        assign high_len  = ({1'b0, ratio_eff} + ONE_WIDE) >> 1;
        assign at_wrap   = (cnt == ratio_eff - ONE);
        assign accept    = cfg_valid && cfg_ready && (cfg_channel == 4'(c));

        always_ff @(posedge input_clock) begin
            if (reset) begin
                ratio   <= DEFAULT_N;
                shadow  <= '0;
                pending <= 1'b0;
                cnt     <= '0;
                clock_q <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                if (!running) begin
                    cnt     <= '0;
                    clock_q <= 1'b0;
                    tick_q  <= 1'b0;
                    if (pending) begin
                        ratio   <= shadow;
                        pending <= 1'b0;
                    end
                end else if (sync_hit) begin
                    tick_q  <= 1'b1;
                    clock_q <= 1'b1;
                    cnt     <= (ratio_eff == ONE) ? '0 : ONE;
                    ratio   <= ratio_eff;
                    pending <= 1'b0;
                end else begin
                    tick_q  <= (cnt == '0);
                    clock_q <= ({1'b0, cnt} < high_len);
                    if (at_wrap) begin
                        cnt <= '0;
                        if (pending) begin
                            ratio   <= shadow;
                            pending <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                // Accept only happens with pending low, so it never races an apply.
                if (accept) begin
                    shadow  <= cfg_divisor;
                    pending <= 1'b1;
                end
            end
        end

        assign cfg_pending[c]  = pending;
        assign output_clock[c] = clock_q;
        assign output_tick[c]  = tick_q;
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench for clock_divider_multi: a period-position reference model predicts each edge,
// a negedge monitor pops and compares. Follows CLOCK_DIVIDER_SYNC_EN when it is defined.
module tb_clock_divider_multi;

    localparam int CH      = 4;
    localparam int DW      = 8;
    localparam int DEF_DIV = 2;

    logic          input_clock = 1'b0;
    logic          reset;
    logic [CH-1:0] enable;
    logic          sync;
    logic          cfg_valid;
    logic [3:0]    cfg_channel;
    logic [DW-1:0] cfg_divisor;
    logic          cfg_ready;
    logic [CH-1:0] cfg_pending;
    logic [CH-1:0] output_clock;
    logic [CH-1:0] output_tick;

    clock_divider_multi #(
        .CHANNELS(CH),
        .DIV_WIDTH(DW),
        .DEFAULT_DIVISION(DEF_DIV)
    ) dut (
        .input_clock(input_clock),
        .reset(reset),
        .enable(enable),
        .sync(sync),
        .cfg_valid(cfg_valid),
        .cfg_channel(cfg_channel),
        .cfg_divisor(cfg_divisor),
        .cfg_ready(cfg_ready),
        .cfg_pending(cfg_pending),
        .output_clock(output_clock),
        .output_tick(output_tick)
    );

    always #5 input_clock = ~input_clock;

    typedef struct {
        int            tag;
        logic [CH-1:0] clk_v;
        logic [CH-1:0] tick_v;
        logic [CH-1:0] pend_v;
    } out_exp_t;

    typedef struct {
        int   tag;
        logic ready;
    } rdy_exp_t;

    out_exp_t oq[$];
    rdy_exp_t rq[$];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    // Reference state: active ratio, staged ratio, staged flag, cycles elapsed in the current period.
    int m_ratio[CH];
    int m_shadow[CH];
    int m_elapsed[CH];
    bit m_pend[CH];

    always @(posedge input_clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, actual, expected);
        end
    endtask

    // Monitor: compares whatever expectations fall due on this cycle.
    always @(negedge input_clock) begin
        rdy_exp_t re;
        out_exp_t oe;
        while (rq.size() > 0 && rq[0].tag == cyc) begin
            re = rq.pop_front();
            checkOutput("cfg_ready", 32'(cfg_ready), 32'(re.ready));
        end
        while (oq.size() > 0 && oq[0].tag == cyc) begin
            oe = oq.pop_front();
            checkOutput("output_clock", 32'(output_clock), 32'(oe.clk_v));
            checkOutput("output_tick", 32'(output_tick), 32'(oe.tick_v));
            checkOutput("cfg_pending", 32'(cfg_pending), 32'(oe.pend_v));
        end
    end

    task automatic predict(input bit rst, input logic [CH-1:0] en, input bit sy,
                           input bit v, input logic [3:0] ch, input logic [DW-1:0] div);
        out_exp_t oe;
        rdy_exp_t re;
        bit       rdy;
        bit       sync_on;
        int       chi;
        chi = int'(ch);
        rdy = (chi >= CH) ? 1'b1 : !m_pend[chi];
`ifdef CLOCK_DIVIDER_SYNC_EN
        sync_on = sy;
`else
        sync_on = 1'b0;
`endif
        re.tag   = cyc;
        re.ready = rdy;
        rq.push_back(re);
        oe.tag    = cyc + 1;
        oe.clk_v  = '0;
        oe.tick_v = '0;
        oe.pend_v = '0;
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                m_ratio[c]   = DEF_DIV;
                m_shadow[c]  = 0;
                m_pend[c]    = 1'b0;
                m_elapsed[c] = 0;
            end else begin
                if (sync_on && m_pend[c]) begin
                    m_ratio[c] = m_shadow[c];
                    m_pend[c]  = 1'b0;
                end
                if (!en[c] || m_ratio[c] == 0) begin
                    m_elapsed[c] = 0;
                    if (m_pend[c]) begin
                        m_ratio[c] = m_shadow[c];
                        m_pend[c]  = 1'b0;
                    end
                end else if (sync_on) begin
                    oe.tick_v[c] = 1'b1;
                    oe.clk_v[c]  = 1'b1;
                    m_elapsed[c] = (m_ratio[c] == 1) ? 0 : 1;
                end else begin
                    oe.tick_v[c] = (m_elapsed[c] == 0);
                    oe.clk_v[c]  = (2 * m_elapsed[c] < m_ratio[c]);
                    m_elapsed[c] = m_elapsed[c] + 1;
                    if (m_elapsed[c] == m_ratio[c]) begin
                        m_elapsed[c] = 0;
                        if (m_pend[c]) begin
                            m_ratio[c] = m_shadow[c];
                            m_pend[c]  = 1'b0;
                        end
                    end
                end
                if (v && rdy && chi == c) begin
                    m_shadow[c] = int'(div);
                    m_pend[c]   = 1'b1;
                end
            end
            oe.pend_v[c] = m_pend[c];
        end
        oq.push_back(oe);
    endtask

    task automatic applyStimulus(input bit rst, input logic [CH-1:0] en, input bit sy,
                                 input bit v, input logic [3:0] ch, input logic [DW-1:0] div);
        reset       = rst;
        enable      = en;
        sync        = sy;
        cfg_valid   = v;
        cfg_channel = ch;
        cfg_divisor = div;
        predict(rst, en, sy, v, ch, div);
        @(posedge input_clock);
        #1;
    endtask

    task automatic runIdle(input int n, input logic [CH-1:0] en);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, en, 1'b0, 1'b0, 4'd0, '0);
    endtask

    initial begin
        for (int c = 0; c < CH; c++) begin
            m_ratio[c]   = DEF_DIV;
            m_shadow[c]  = 0;
            m_pend[c]    = 1'b0;
            m_elapsed[c] = 0;
        end
        reset       = 1'b1;
        enable      = '0;
        sync        = 1'b0;
        cfg_valid   = 1'b0;
        cfg_channel = '0;
        cfg_divisor = '0;
        @(posedge input_clock);
        #1;

        applyStimulus(1'b1, '0, 1'b0, 1'b0, 4'd0, '0);
        applyStimulus(1'b1, '0, 1'b0, 1'b0, 4'd0, '0);
        runIdle(8, 4'hF);

        runIdle(1, 4'h0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 4'd1, 8'd3);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 4'd2, 8'd1);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 4'd3, 8'd4);
        runIdle(1, 4'h0);
        runIdle(12, 4'hF);

        applyStimulus(1'b0, 4'hF, 1'b0, 1'b1, 4'd0, 8'd4);
        runIdle(6, 4'hF);
        applyStimulus(1'b0, 4'hF, 1'b0, 1'b1, 4'd0, 8'd5);
        applyStimulus(1'b0, 4'hF, 1'b0, 1'b1, 4'd0, 8'd6);
        runIdle(16, 4'hF);

        applyStimulus(1'b0, 4'hF, 1'b0, 1'b1, 4'd2, 8'd0);
        applyStimulus(1'b0, 4'hF, 1'b0, 1'b1, 4'd9, 8'd7);
        runIdle(8, 4'hF);

        applyStimulus(1'b0, 4'hF, 1'b0, 1'b1, 4'd0, 8'd3);
        applyStimulus(1'b0, 4'hF, 1'b0, 1'b1, 4'd1, 8'd4);
        runIdle(7, 4'hF);
        applyStimulus(1'b0, 4'hF, 1'b1, 1'b0, 4'd0, '0);
        runIdle(12, 4'hF);

        applyStimulus(1'b0, 4'hF, 1'b0, 1'b1, 4'd3, 8'd6);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 4'd0, '0);
        runIdle(6, 4'hF);

        // Randomised traffic: occasional reset/sync, frequent writes including invalid channels.
        begin
            logic [CH-1:0] en_r;
            en_r = 4'hF;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 19) == 0) en_r = CH'($urandom);
                applyStimulus($urandom_range(0, 199) == 0, en_r, $urandom_range(0, 24) == 0,
                              $urandom_range(0, 2) == 0, 4'($urandom_range(0, 5)),
                              8'($urandom_range(0, 6)));
            end
        end

        runIdle(2, 4'hF);
        repeat (2) @(posedge input_clock);
        #1;
        total++;
        if (oq.size() > 1 || rq.size() > 1) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain actual=%0d/%0d expected=<=1/<=1", oq.size(), rq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
